// File: rtl/slot_timer_arbiter.sv
// slot_timer_arbiter: round-robin grant of a shared mod-len slot counter among NREQ requesters.
// Define SLOT_B2B_EN to allow a new grant on the done cycle (no idle gap between slots).
module slot_timer_arbiter #(
    parameter int NREQ = 4,
    parameter int WIDTH = 8,
    localparam int IW = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic                  done,
    output logic [IW-1:0]         done_id
);
`ifdef SLOT_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d, elig;
    logic [WIDTH-1:0] count_q, count_d, len_q, len_d, win_len;
    logic [IW-1:0] last_q, last_d, done_id_q, done_id_d, win, cur, idx;
    logic done_q, done_d, win_vld, arb, go, adv;
    logic [WIDTH-1:0] len_a [NREQ];
    for (genvar i = 0; i < NREQ; i++) begin : g_len
        assign len_a[i] = len[i*WIDTH +: WIDTH];
    end
    // Search from last+NREQ down to last+1 so the nearest index after last wins.
    always_comb begin
        elig = (state_q == RUN && B2B) ? req & ~grant_q : req;
        win_vld = 1'b0;
        win = last_q;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(last_q) + k) % NREQ);
            if (elig[idx]) begin
                win_vld = 1'b1;
                win = idx;
            end
        end
        cur = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) cur = IW'(i);
        end
        win_len = (len_a[win] == '0) ? WIDTH'(1) : len_a[win];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            count_q   <= '0;
            len_q     <= '0;
            last_q    <= IW'(NREQ - 1);
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            count_q   <= count_d;
            len_q     <= len_d;
            last_q    <= last_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end
    // done_q marks the final cycle of a slot, so RUN with done_q means the slot ends at this edge.
    always_comb begin
        arb = (state_q == IDLE) || (done_q && B2B);
        go = arb && win_vld;
        adv = (state_q == RUN) && !done_q && |(req & grant_q);
        state_d = (go || adv) ? RUN : IDLE;
    end
    always_comb begin
        grant_d = go ? NREQ'(1) << win : adv ? grant_q : '0;
        count_d = adv ? count_q + WIDTH'(1) : '0;
        len_d = go ? win_len : len_q;
        last_d = go ? win : last_q;
        done_d = go ? (win_len == WIDTH'(1)) : adv && (count_q + WIDTH'(1) == len_q - WIDTH'(1));
        done_id_d = done_d ? (go ? win : cur) : done_id_q;
    end
    assign grant = grant_q;
    assign busy = |grant_q;
    assign count = count_q;
    assign done = done_q;
    assign done_id = done_id_q;
endmodule

// File: tb/tb_slot_timer_arbiter.sv
// tb_slot_timer_arbiter: directed tests plus a random phase, checked every cycle against a slot-level model.
// Expectations follow SLOT_B2B_EN when the macro is defined for the build.
module tb_slot_timer_arbiter;
    localparam int NREQ = 4;
    localparam int WIDTH = 8;
    localparam int IW = $clog2(NREQ);
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ*WIDTH-1:0] len = '0;
    logic [NREQ-1:0] grant;
    logic busy;
    logic [WIDTH-1:0] count;
    logic done;
    logic [IW-1:0] done_id;
    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;
    int m_own = -1, m_pos = 0, m_len = 0, m_last = NREQ - 1, m_did = 0, m_fin = 0;
    bit m_done = 1'b0;
    slot_timer_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req(req), .len(len), .grant(grant),
        .busy(busy), .count(count), .done(done), .done_id(done_id)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask
    task automatic pick(input int excl);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_last + k) % NREQ;
            if (req[i] && i != excl) begin
                m_own = i;
                m_len = (len[i*WIDTH +: WIDTH] == 0) ? 1 : int'(len[i*WIDTH +: WIDTH]);
                m_pos = 0;
                m_last = i;
                m_done = (m_len == 1);
                m_did = i;
                return;
            end
        end
    endtask
    // Slot-level model: an owner index, a position within the slot, and the round-robin pointer.
    always @(posedge clk) begin
        if (rst) begin
            m_own = -1; m_pos = 0; m_len = 0; m_last = NREQ - 1; m_done = 0; m_did = 0;
        end else if (m_own < 0) begin
            pick(-1);
        end else if (m_done) begin
            m_fin = m_own;
            m_own = -1; m_pos = 0; m_done = 0;
`ifdef SLOT_B2B_EN
            pick(m_fin);
`endif
        end else if (!req[m_own]) begin
            m_own = -1; m_pos = 0; m_done = 0;
        end else begin
            m_pos++;
            m_done = (m_pos == m_len - 1);
        end
    end
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_grant", int'(grant), m_own < 0 ? 0 : (1 << m_own));
            chk("model_busy", int'(busy), int'(m_own >= 0));
            chk("model_count", int'(count), m_own < 0 ? 0 : m_pos);
            chk("model_done", int'(done), int'(m_done));
            if (m_done) chk("model_done_id", int'(done_id), m_did);
        end
    end
    task automatic set_len(input int i, input int v);
        len[i*WIDTH +: WIDTH] = WIDTH'(v);
    endtask
    task automatic do_reset;
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask
`ifdef SLOT_B2B_EN
    int exp_ord[14] = '{1, 1, 2, 2, 4, 4, 8, 8, 1, 1, 2, 2, 4, 4};
    localparam int EXP_DONES = 7;
`else
    int exp_ord[14] = '{1, 1, 0, 2, 2, 0, 4, 4, 0, 8, 8, 0, 1, 1};
    localparam int EXP_DONES = 5;
`endif
    initial begin
        int nd;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_done_id", int'(done_id), 0);
        rst = 1'b0;
        req = 4'b0001;
        set_len(0, 5);
        @(negedge clk);
        chk("t1_grant_c1", int'(grant), 1);
        chk("t1_count_c1", int'(count), 0);
        repeat (3) @(negedge clk);
        chk("t1_count_c4", int'(count), 3);
        chk("t1_done_c4", int'(done), 0);
        @(negedge clk);
        chk("t1_count_c5", int'(count), 4);
        chk("t1_done_c5", int'(done), 1);
        chk("t1_done_id", int'(done_id), 0);
        req = '0;
        @(negedge clk);
        chk("t1_grant_c6", int'(grant), 0);
        do_reset;
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_len(i, 2);
        nd = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            chk($sformatf("t2_order_c%0d", c + 1), int'(grant), exp_ord[c]);
            if (done) begin
                chk("t2_done_id_seq", int'(done_id), nd % NREQ);
                nd++;
            end
        end
        chk("t2_done_count", nd, EXP_DONES);
        req = '0;
        @(negedge clk);
        do_reset;
        req = 4'b0010;
        set_len(1, 0);
        @(negedge clk);
        chk("t3_grant", int'(grant), 2);
        chk("t3_count", int'(count), 0);
        chk("t3_done", int'(done), 1);
        chk("t3_done_id", int'(done_id), 1);
        req = '0;
        @(negedge clk);
        chk("t3_grant_after", int'(grant), 0);
        do_reset;
        req = 4'b0100;
        set_len(2, 10);
        set_len(3, 3);
        @(negedge clk);
        chk("t4_grant", int'(grant), 4);
        req = 4'b1100;
        repeat (3) @(negedge clk);
        chk("t4_count3", int'(count), 3);
        req = 4'b1000;
        @(negedge clk);
        chk("t4_abort_grant", int'(grant), 0);
        chk("t4_abort_count", int'(count), 0);
        chk("t4_abort_done", int'(done), 0);
        @(negedge clk);
        chk("t4_next_grant", int'(grant), 8);
        chk("t4_next_count", int'(count), 0);
        req = '0;
        @(negedge clk);
        do_reset;
        req = 4'b0001;
        set_len(0, 8);
        repeat (7) @(negedge clk);
        chk("t5_count6", int'(count), 6);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("t5_rst_grant", int'(grant), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_count", int'(count), 0);
        chk("t5_rst_done", int'(done), 0);
        chk("t5_rst_done_id", int'(done_id), 0);
        rst = 1'b0;
        req = 4'b1010;
        @(negedge clk);
        chk("t5_first_grant", int'(grant), 2);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) req = NREQ'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) set_len($urandom_range(0, NREQ - 1), $urandom_range(0, 4));
        end
        req = '0;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
